// File: rtl/mem_pkg.sv
// Shared types and constants for the memory handshake unit.
package mem_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_handshake_unit_if.sv
// Controller-to-memory bus: request strobes, MAR/MDR contents and the MFC handshake.
interface mem_handshake_unit_if;
    import mem_pkg::*;

    logic              read;
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              MFC;
    logic              busy;
    logic              err;

    modport master (
        output read, write, addr, wdata,
        input  rdata, MFC, busy, err
    );

    modport slave (
        input  read, write, addr, wdata,
        output rdata, MFC, busy, err
    );

endinterface

// File: rtl/mem_array.sv
// Synchronous single-port word RAM. The array itself is never cleared; only the read register
// resets.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Read register only moves on a read completion, so it holds between accesses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/mem_handshake_unit.sv
// Request FSM, wait-state counter and four-phase MFC handshake in front of mem_array.
// Optional macro MEM_BOUNDS_CHECK_EN: out-of-range addresses complete with err instead of wrapping.
module mem_handshake_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_handshake_unit_if.slave   bus
);

    localparam int unsigned CNT_W = 4;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [WORD_W-1:0]     r_wdata;
    logic                  r_op;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_access;
    logic                  w_we;
    logic                  w_re;
    logic [WORD_W-1:0]     w_ram_rdata;

    assign w_accept   = (r_state == IDLE) && (bus.read ^ bus.write);
    assign w_complete = (r_state == WAIT) && (r_cnt == '0);

`ifdef MEM_BOUNDS_CHECK_EN
    logic r_oob;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_oob <= 1'b0;
        end else if (w_accept) begin
            r_oob <= (bus.addr >> DEPTH_LOG2) != '0;
        end
    end

    assign w_access = w_complete && !r_oob;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^bus.addr[WORD_W-1:DEPTH_LOG2];
    assign w_access      = w_complete;
`endif

    assign w_we = w_access && (r_op == OP_WRITE);
    assign w_re = w_access && (r_op == OP_READ);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.read && bus.write) begin
                    w_err_nxt = 1'b1;
                end else if (bus.read ^ bus.write) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
`ifdef MEM_BOUNDS_CHECK_EN
                    w_err_nxt   = r_oob;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DONE: begin
                if (!bus.read && !bus.write) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Request fields are captured once at accept; later bus changes are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_READ;
        end else if (w_accept) begin
            r_addr  <= bus.addr[DEPTH_LOG2-1:0];
            r_wdata <= bus.wdata;
            r_op    <= bus.write ? OP_WRITE : OP_READ;
        end
    end

    mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clock (clock),
        .reset (reset),
        .we    (w_we),
        .re    (w_re),
        .addr  (r_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    assign bus.rdata = w_ram_rdata;
    assign bus.MFC   = (r_state == DONE);
    assign bus.busy  = (r_state != IDLE);
    assign bus.err   = r_err;

endmodule

// File: tb/tb_mem_handshake_unit.sv
// Directed self-checking bench for mem_handshake_unit (WAIT_CYCLES=2, 256 words).
module tb_mem_handshake_unit;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_miss;

    mem_handshake_unit_if bus ();

    mem_handshake_unit #(
        .DEPTH_LOG2  (8),
        .WAIT_CYCLES (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request; bus fields are scrambled after accept to prove they were latched.
    task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rdata, input bit exp_err, input string tag);
        bus.read  = !wr;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        check({tag, " busy@accept"}, 16'(bus.busy), 16'd1);
        check({tag, " mfc@accept"}, 16'(bus.MFC), 16'd0);
        bus.addr  = a ^ 16'h0030;
        bus.wdata = ~d;
        tick();
        check({tag, " mfc@+1"}, 16'(bus.MFC), 16'd0);
        tick();
        check({tag, " mfc@+2"}, 16'(bus.MFC), 16'd1);
        check({tag, " err@mfc"}, 16'(bus.err), 16'(exp_err));
        check({tag, " rdata@mfc"}, bus.rdata, exp_rdata);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        tick();
        check({tag, " mfc@release"}, 16'(bus.MFC), 16'd0);
        check({tag, " busy@release"}, 16'(bus.busy), 16'd0);
        check({tag, " err@release"}, 16'(bus.err), 16'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        reset     = 1'b0;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.addr  = 16'h0000;
        bus.wdata = 16'h0000;
        tick();
        tick();
        check("reset mfc", 16'(bus.MFC), 16'd0);
        check("reset busy", 16'(bus.busy), 16'd0);
        check("reset err", 16'(bus.err), 16'd0);
        check("reset rdata", bus.rdata, 16'h0000);
        reset = 1'b1;
        tick();

        // Write then read back; a write leaves rdata alone.
        access(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, "wr10");
        access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "rd10");

        // Latch check: address moves to 0x0020 during WAIT, data must come from 0x0010.
        access(1'b1, 16'h0020, 16'h2020, 16'hBEEF, 1'b0, "wr20");
        access(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "rd10latch");
        access(1'b0, 16'h0020, 16'h0000, 16'h2020, 1'b0, "rd20");

        // Handshake hold with read kept high five cycles past MFC.
        access(1'b1, 16'h0003, 16'h3333, 16'h2020, 1'b0, "wr03");
        bus.read = 1'b1;
        bus.addr = 16'h0003;
        tick();
        tick();
        tick();
        check("hold mfc rise", 16'(bus.MFC), 16'd1);
        check("hold rdata", bus.rdata, 16'h3333);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold mfc", 16'(bus.MFC), 16'd1);
            check("hold busy", 16'(bus.busy), 16'd1);
        end
        bus.read = 1'b0;
        tick();
        check("hold mfc clear", 16'(bus.MFC), 16'd0);
        check("hold busy clear", 16'(bus.busy), 16'd0);
        check("hold rdata kept", bus.rdata, 16'h3333);

        // Simultaneous read and write is rejected.
        bus.read  = 1'b1;
        bus.write = 1'b1;
        bus.addr  = 16'h0003;
        bus.wdata = 16'hDEAD;
        tick();
        check("illegal err", 16'(bus.err), 16'd1);
        check("illegal mfc", 16'(bus.MFC), 16'd0);
        check("illegal busy", 16'(bus.busy), 16'd0);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        tick();
        check("illegal err drop", 16'(bus.err), 16'd0);
        check("illegal busy idle", 16'(bus.busy), 16'd0);
        access(1'b0, 16'h0003, 16'h0000, 16'h3333, 1'b0, "rd03 after illegal");

        // Reset in the middle of a write aborts it immediately.
        access(1'b1, 16'h0005, 16'h0000, 16'h3333, 1'b0, "wr05 zero");
        bus.write = 1'b1;
        bus.addr  = 16'h0005;
        bus.wdata = 16'h1234;
        tick();
        tick();
        check("abort busy before", 16'(bus.busy), 16'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort mfc", 16'(bus.MFC), 16'd0);
        check("abort busy", 16'(bus.busy), 16'd0);
        check("abort err", 16'(bus.err), 16'd0);
        check("abort rdata", bus.rdata, 16'h0000);
        bus.write = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        tick();
        access(1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, "rd05 after abort");

        // Upper address bits: wrap by default, rejected at completion with the bounds check.
`ifdef MEM_BOUNDS_CHECK_EN
        access(1'b1, 16'h0105, 16'hA5A5, 16'h0000, 1'b1, "wr105 oob");
        access(1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0, "rd05 oob");
        access(1'b0, 16'h0105, 16'h0000, 16'h0000, 1'b1, "rd105 oob");
`else
        access(1'b1, 16'h0105, 16'hA5A5, 16'h0000, 1'b0, "wr105 wrap");
        access(1'b0, 16'h0005, 16'h0000, 16'hA5A5, 1'b0, "rd05 wrap");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
